// File: rtl/sprite_pkg.sv
// Shared types and timing constants for the sprite line engine.
package sprite_pkg;

    localparam int HPIX        = 640;
    localparam int VACTIVE     = 480;
    localparam int VTOTAL      = 525;
    localparam int LINE_CYCLES = 1600;

    localparam logic [1:0] REG_ATTR    = 2'd0;
    localparam logic [1:0] REG_PATTERN = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;

    // Attribute word layout, msb first.
    typedef struct packed {
        logic       en;
        logic       hflip;
        logic [1:0] bank;
        logic [7:0] base;
        logic [9:0] x;
        logic [9:0] y;
    } attr_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FETCH_ATTR,
        ST_CHECK,
        ST_FETCH_ROW,
        ST_READ_PIX,
        ST_WRITE_PIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sprite_line_engine_line_buffer.sv
// Single-port line RAM: registered read, synchronous write (old data on read-during-write).
module line_buffer
    import sprite_pkg::*;
#(
    parameter int DEPTH = HPIX,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        if (we)
            mem[addr] <= wdata;
    end

endmodule

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite renderer into a double-buffered line of palette indices,
// with read-and-clear display of the front buffer.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int N_SPRITES    = 16,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int BPP          = 2,
    parameter int PAT_DEPTH    = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           chipselect,
    input  logic           write,
    input  logic [11:0]    address,
    input  logic [31:0]    writedata,
    input  logic [10:0]    hcount,
    input  logic [9:0]     vcount,
    output logic [BPP+1:0] pix_index,
    output logic           pix_valid,
    output logic           line_overflow,
    output logic           render_overrun,
    output logic           busy
);

    localparam int AW   = $clog2(N_SPRITES);
    localparam int PW   = $clog2(PAT_DEPTH);
    localparam int KW   = $clog2(SPRITE_W);
    localparam int CW   = $clog2(MAX_PER_LINE + 1);
    localparam int LW   = $clog2(HPIX);
    localparam int PIXW = BPP + 2;
    localparam int ROWW = SPRITE_W * BPP;

    state_t            state;
    logic              ctrl_enable;
    logic              sel;
    logic [LW-1:0]     init_addr;
    logic [AW-1:0]     spr_idx;
    logic [CW-1:0]     drawn;
    logic [9:0]        vnext_r;
    logic [9:0]        spr_x;
    logic [1:0]        spr_bank;
    logic              spr_hflip;
    logic [ROWW-1:0]   row_data;
    logic [KW-1:0]     k;

    attr_t             attr_mem [N_SPRITES];
    logic [ROWW-1:0]   pat_mem  [PAT_DEPTH];
    attr_t             attr_rdata;
    logic [ROWW-1:0]   pat_rdata;
    logic [PW-1:0]     pat_raddr;
    logic              bus_wr;

    assign bus_wr = chipselect && write;

    always_ff @(posedge clk) begin
        if (bus_wr && address[11:10] == REG_ATTR)
            attr_mem[address[AW-1:0]] <= attr_t'(writedata);
        if (bus_wr && address[11:10] == REG_PATTERN)
            pat_mem[address[PW-1:0]] <= writedata[ROWW-1:0];
        attr_rdata <= attr_mem[spr_idx];
        pat_rdata  <= pat_mem[pat_raddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctrl_enable <= 1'b0;
        else if (bus_wr && address[11:10] == REG_CTRL && address[9:0] == '0)
            ctrl_enable <= writedata[0];
    end

    logic [9:0]  vnext, col, dy;
    logic        hit, last_spr, disp_active, line_start, line_end;
    logic [10:0] cur_col;
    logic        col_ok;
    logic [KW-1:0]  kp;
    logic [BPP-1:0] field;

    assign vnext       = (vcount == 10'(VTOTAL - 1)) ? '0 : vcount + 10'd1;
    assign col         = hcount[10:1];
    assign disp_active = (col < 10'(HPIX)) && (vcount < 10'(VACTIVE));
    assign line_start  = (hcount == '0);
    assign line_end    = (hcount == 11'(LINE_CYCLES - 1));
    assign last_spr    = (spr_idx == AW'(N_SPRITES - 1));

    // Unsigned wrap makes y > vnext fall outside the sprite height.
    assign dy        = vnext_r - attr_rdata.y;
    assign hit       = attr_rdata.en && (dy < 10'(SPRITE_H));
    assign pat_raddr = PW'(attr_rdata.base) + PW'(dy);

    assign cur_col = 11'(spr_x) + 11'(k);
    assign col_ok  = cur_col < 11'(HPIX);
    assign kp      = spr_hflip ? KW'(SPRITE_W - 1) - k : k;
    assign field   = BPP'(row_data >> (32'(kp) * BPP));

    logic [LW-1:0]   r_addr, d_addr;
    logic            r_we, d_we;
    logic [PIXW-1:0] r_wdata, front_rdata, back_rdata;
    logic [LW-1:0]   b_addr  [2];
    logic            b_we    [2];
    logic [PIXW-1:0] b_wdata [2];
    logic [PIXW-1:0] b_rdata [2];

    assign r_addr  = col_ok ? LW'(cur_col) : '0;
    assign r_we    = (state == ST_WRITE_PIX) && col_ok && (field != '0) && (back_rdata == '0);
    assign r_wdata = {spr_bank, field};
    assign d_addr  = (col < 10'(HPIX)) ? LW'(col) : '0;
    assign d_we    = disp_active && hcount[0];

    assign front_rdata = sel ? b_rdata[1] : b_rdata[0];
    assign back_rdata  = sel ? b_rdata[0] : b_rdata[1];

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (state == ST_INIT) begin
                b_addr[i]  = init_addr;
                b_we[i]    = 1'b1;
                b_wdata[i] = '0;
            end else if (sel == 1'(i)) begin
                b_addr[i]  = d_addr;
                b_we[i]    = d_we;
                b_wdata[i] = '0;
            end else begin
                b_addr[i]  = r_addr;
                b_we[i]    = r_we;
                b_wdata[i] = r_wdata;
            end
        end
    end

    line_buffer #(.DEPTH(HPIX), .WIDTH(PIXW)) u_buf0 (
        .clk(clk), .addr(b_addr[0]), .we(b_we[0]), .wdata(b_wdata[0]), .rdata(b_rdata[0])
    );

    line_buffer #(.DEPTH(HPIX), .WIDTH(PIXW)) u_buf1 (
        .clk(clk), .addr(b_addr[1]), .we(b_we[1]), .wdata(b_wdata[1]), .rdata(b_rdata[1])
    );

    // Odd hcount: front[x] data is back from the even-cycle read, so latch it for two cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_index <= '0;
            pix_valid <= 1'b0;
            sel       <= 1'b0;
        end else begin
            if (hcount[0]) begin
                pix_index <= disp_active ? front_rdata : '0;
                pix_valid <= disp_active;
            end
            if (line_end)
                sel <= ~sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_INIT;
            busy           <= 1'b1;
            init_addr      <= '0;
            spr_idx        <= '0;
            drawn          <= '0;
            vnext_r        <= '0;
            spr_x          <= '0;
            spr_bank       <= '0;
            spr_hflip      <= 1'b0;
            row_data       <= '0;
            k              <= '0;
            line_overflow  <= 1'b0;
            render_overrun <= 1'b0;
        end else begin
            if (line_start && vcount == '0) begin
                line_overflow  <= 1'b0;
                render_overrun <= 1'b0;
            end
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == LW'(HPIX - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (line_start && ctrl_enable && vnext < 10'(VACTIVE)) begin
                        vnext_r <= vnext;
                        spr_idx <= '0;
                        drawn   <= '0;
                        state   <= ST_FETCH_ATTR;
                    end
                end
                ST_FETCH_ATTR: state <= ST_CHECK;
                ST_CHECK: begin
                    spr_x     <= attr_rdata.x;
                    spr_bank  <= attr_rdata.bank;
                    spr_hflip <= attr_rdata.hflip;
                    k         <= '0;
                    if (hit && drawn != CW'(MAX_PER_LINE)) begin
                        drawn <= drawn + 1'b1;
                        state <= ST_FETCH_ROW;
                    end else begin
                        if (hit)
                            line_overflow <= 1'b1;
                        if (last_spr) begin
                            state <= ST_DONE;
                        end else begin
                            spr_idx <= spr_idx + 1'b1;
                            state   <= ST_FETCH_ATTR;
                        end
                    end
                end
                ST_FETCH_ROW: begin
                    row_data <= pat_rdata;
                    state    <= ST_READ_PIX;
                end
                ST_READ_PIX: state <= ST_WRITE_PIX;
                ST_WRITE_PIX: begin
                    k <= k + 1'b1;
                    if (k != KW'(SPRITE_W - 1)) begin
                        state <= ST_READ_PIX;
                    end else if (last_spr) begin
                        state <= ST_DONE;
                    end else begin
                        spr_idx <= spr_idx + 1'b1;
                        state   <= ST_FETCH_ATTR;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (line_end && state != ST_INIT && state != ST_IDLE && state != ST_DONE) begin
                state          <= ST_IDLE;
                render_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: drives hcount/vcount line by line and checks captured pixels.
module tb_sprite_line_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write;
    logic [11:0] address;
    logic [31:0] writedata;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [3:0]  pix_index;
    logic        pix_valid, line_overflow, render_overrun, busy;

    int checks = 0;
    int errors = 0;
    int outside_bad = 0;
    logic [3:0] cap  [640];
    logic       capv [640];

    always #5 clk = ~clk;

    sprite_line_engine dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
        .pix_index(pix_index), .pix_valid(pix_valid), .line_overflow(line_overflow),
        .render_overrun(render_overrun), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    function automatic logic [31:0] mk_attr(input logic hf, input logic [1:0] bank,
                                            input logic [7:0] base, input logic [9:0] x,
                                            input logic [9:0] y);
        return {1'b1, hf, bank, base, x, y};
    endfunction

    function automatic int count_not(input int lo, input int hi, input logic [3:0] val);
        int n = 0;
        for (int i = lo; i <= hi; i++)
            if (cap[i] !== val) n++;
        return n;
    endfunction

    function automatic int count_invalid();
        int n = 0;
        for (int i = 0; i < 640; i++)
            if (capv[i] !== 1'b1) n++;
        return n;
    endfunction

    // One full line; pixel x is captured just after the edge at hcount 2x+1.
    task automatic run_line(input int v);
        for (int h = 0; h < 1600; h++) begin
            hcount = 11'(h);
            vcount = 10'(v);
            @(posedge clk);
            #1;
            if (h % 2 == 1 && h < 1280) begin
                cap[(h - 1) / 2]  = pix_index;
                capv[(h - 1) / 2] = pix_valid;
            end else if (h >= 1281 && (pix_valid !== 1'b0 || pix_index !== 4'd0)) begin
                outside_bad++;
            end
        end
        hcount = 11'd1400;
    endtask

    task automatic wait_init(input string tag);
        repeat (639) @(posedge clk);
        #1;
        check({tag, "_busy_639"}, busy, 1);
        @(posedge clk);
        #1;
        check({tag, "_busy_640"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0;
        address = '0; writedata = '0; hcount = 11'd1400; vcount = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_index", pix_index, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_overflow", line_overflow, 0);
        check("rst_overrun", render_overrun, 0);
        check("rst_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        wait_init("init");

        for (int i = 0; i < 16; i++)
            bus_write(12'(i), 32'h0);
        run_line(524);
        run_line(0);
        check("off_line0_zero", count_not(0, 639, 4'd0), 0);
        check("off_line0_valid", count_invalid(), 0);
        run_line(1);
        check("off_line1_zero", count_not(0, 639, 4'd0), 0);
        check("off_flags", {30'd0, line_overflow, render_overrun}, 0);

        // single sprite, bank 2, field 1 at pixel 200
        bus_write(12'h000, mk_attr(1'b0, 2'd2, 8'd0, 10'd200, 10'd100));
        bus_write(12'h400, 32'h0000_0001);
        bus_write(12'h800, 32'h1);
        run_line(98);
        run_line(99);
        check("l99_empty", count_not(0, 639, 4'd0), 0);
        run_line(100);
        check("l100_px200", cap[200], 9);
        check("l100_px201", cap[201], 0);
        check("l100_rest", count_not(0, 199, 4'd0) + count_not(202, 639, 4'd0), 0);
        run_line(115);
        run_line(116);
        check("l116_empty", count_not(0, 639, 4'd0), 0);

        // priority: lower index wins where both are opaque
        bus_write(12'h000, mk_attr(1'b0, 2'd1, 8'd0, 10'd300, 10'd200));
        bus_write(12'h001, mk_attr(1'b0, 2'd3, 8'd16, 10'd300, 10'd200));
        bus_write(12'h400, 32'h0000_0005);
        bus_write(12'h410, 32'hFFFF_FFFF);
        run_line(199);
        run_line(200);
        check("prio_px300", cap[300], 5);
        check("prio_px301", cap[301], 5);
        check("prio_px302_315", count_not(302, 315, 4'd15), 0);
        check("prio_px316", cap[316], 0);
        check("prio_px299", cap[299], 0);

        // horizontal flip
        bus_write(12'h001, 32'h0);
        bus_write(12'h000, mk_attr(1'b1, 2'd1, 8'd32, 10'd40, 10'd10));
        bus_write(12'h420, 32'h0000_0003);
        run_line(9);
        run_line(10);
        check("flip_px55", cap[55], 7);
        check("flip_px40", cap[40], 0);
        check("flip_rest", count_not(0, 54, 4'd0) + count_not(56, 639, 4'd0), 0);

        // nine sprites on line 50; only the first eight are drawn
        bus_write(12'h430, 32'h0000_0001);
        for (int i = 0; i < 9; i++)
            bus_write(12'(i), mk_attr(1'b0, 2'd0, 8'd48, 10'(100 + 20 * i), 10'd50));
        run_line(49);
        check("ovf_set", line_overflow, 1);
        run_line(50);
        for (int i = 0; i < 8; i++)
            check($sformatf("ovf_spr%0d", i), cap[100 + 20 * i], 1);
        check("ovf_spr8_absent", cap[260], 0);
        check("ovf_sticky", line_overflow, 1);
        run_line(0);
        check("ovf_cleared", line_overflow, 0);
        check("no_overrun", render_overrun, 0);

        // right-edge clipping and bottom lines
        for (int i = 1; i < 9; i++)
            bus_write(12'(i), 32'h0);
        bus_write(12'h000, mk_attr(1'b0, 2'd0, 8'd64, 10'd630, 10'd475));
        bus_write(12'h440, 32'hFFFF_FFFF);
        bus_write(12'h444, 32'hFFFF_FFFF);
        run_line(474);
        run_line(475);
        check("edge_630_639", count_not(630, 639, 4'd3), 0);
        check("edge_0_5", count_not(0, 5, 4'd0), 0);
        check("edge_629", cap[629], 0);
        run_line(478);
        run_line(479);
        check("edge_l479_639", cap[639], 3);
        check("edge_l479_630", cap[630], 3);
        check("outside_active", outside_bad, 0);

        // asynchronous reset in the middle of an active line
        for (int h = 0; h < 301; h++) begin
            hcount = 11'(h);
            vcount = 10'd475;
            @(posedge clk);
        end
        #1;
        check("pre_rst_valid", pix_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_pix_index", pix_index, 0);
        check("mid_rst_pix_valid", pix_valid, 0);
        check("mid_rst_busy", busy, 1);
        hcount = 11'd1400;
        @(negedge clk);
        reset = 1'b0;
        wait_init("reinit");
        run_line(474);
        run_line(475);
        check("reinit_disabled", count_not(0, 639, 4'd0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
- Parametrised successor to the single-line sprite PPU path: evaluates up to N_SPRITES attribute entries per scanline and renders the next line into a double-buffered line buffer of palette indices.
- Adds per-line sprite limit, index-order priority, transparency, horizontal flip, palette banks, screen-edge clipping and overrun detection.
- Sits between the Avalon-style bus write port and the colour-table/VGA output stage, and is driven by the existing hcount/vcount timing.

Parameters:
N_SPRITES, 16, attribute entries scanned per line
MAX_PER_LINE, 8, max sprites drawn on one line
SPRITE_W, 16, sprite width in pixels (SPRITE_W*BPP <= 32)
SPRITE_H, 16, sprite height in rows
BPP, 2, bits per pattern pixel; field value 0 = transparent
PAT_DEPTH, 256, pattern RAM words (8-bit address)
HPIX, 640, active pixels per line
VACTIVE, 480, active lines
VTOTAL, 525, total lines per frame
LINE_CYCLES, 1600, clk cycles per line

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
chipselect  in  1  bus select
write  in  1  bus write strobe
address  in  12  [11:10] region: 0 attr, 1 pattern, 2 control; low bits = word index
writedata  in  32  bus write data
hcount  in  11  from vga_counters; pixel column = hcount[10:1]
vcount  in  10  from vga_counters
pix_index  out  2+BPP  palette index {bank, field}; 0 = no sprite
pix_valid  out  1  high while pix_index belongs to the active area
line_overflow  out  1  sticky: some line in the current frame exceeded MAX_PER_LINE
render_overrun  out  1  sticky: render did not finish before line end
busy  out  1  high during INIT clear

Behaviour:
- Reset (async): all outputs 0 except busy=1; control.enable=0; FSM goes to INIT, which clears both line buffers (HPIX cycles, one address per cycle to both buffers), then goes to IDLE with busy=0.
- Attribute word: [31] enable, [30] hflip, [29:28] bank, [27:20] pattern base, [19:10] x, [9:0] y. Control word 0 bit0 = engine enable.
- Attribute and pattern RAMs are simple dual-port: bus write port plus renderer read port with 1-cycle read latency. No conflicts. Updates are not atomic with rendering.
- Line buffers: two buffers of HPIX x (2+BPP) bits. sel selects the front buffer and toggles on hcount==LINE_CYCLES-1.
- Display: for pixel x, read front[x] at hcount=2x and write 0 to front[x] at hcount=2x+1 (read-and-clear). pix_index/pix_valid for pixel x are held on hcount 2x+2 and 2x+3. Outside the active area pix_index=0 and pix_valid=0.
- Render FSM: IDLE -> FETCH_ATTR -> CHECK -> FETCH_ROW -> READ_PIX <-> WRITE_PIX -> (next sprite FETCH_ATTR | DONE) -> IDLE.
  - Start at hcount==0 for vnext = (vcount==VTOTAL-1) ? 0 : vcount+1.
  - Stay in IDLE if enable==0 or vnext>=VACTIVE.
- Hit test: attr enable and (vnext - y) < SPRITE_H, computed as 10-bit unsigned; y>vnext is a miss.
  - Hit with drawn count == MAX_PER_LINE: skip the sprite and set line_overflow.
- Row fetch address = (base + (vnext - y)) mod PAT_DEPTH.
- Pixel k (0..SPRITE_W-1) uses field [BPP*k' +: BPP], where k' = hflip ? SPRITE_W-1-k : k. Screen column = x+k.
- Per pixel: READ_PIX reads back[x+k]; WRITE_PIX writes {bank, field} only if field != 0, the entry read was 0, and x+k < HPIX. Lower sprite index therefore wins.
- Columns >= HPIX are skipped with no wrap; 11-bit sum.
- Cycle budget per sprite: 3 + 2*SPRITE_W.
- Line-end abort: at hcount==LINE_CYCLES-1, if the FSM is not IDLE/DONE, abort to IDLE and set render_overrun. Partial writes stay visible.
- Sticky flags clear at hcount==0 && vcount==0. A set event on the same cycle wins.
- A bus write to control takes effect from the next line start.

Decomposition:
- Package sprite_pkg:
  - attribute field offsets/widths and region codes
  - FSM state enum
  - timing constants HPIX/VACTIVE/VTOTAL/LINE_CYCLES
- One sub-module, line_buffer: single-port HPIX x width RAM with 1-cycle read and synchronous write, instantiated twice. The existing memory module is used for attr/pattern RAMs.

Test Plan:
- Reset -> busy=1 for 640 cycles, then 0. Every pix_index in the first full frame = 0; flags 0.
- Sprite0 {en=1, bank=2, base=0, x=200, y=100}, pattern[0]=0x0000_0001, enable=1 -> line 100 pixel 200 pix_index=9, pixel 201 = 0. Lines 99 and 116 show no sprite.
- Sprite0 and sprite1 at the same x/y, banks 1 and 3, sprite0 row 0x0000_0005, sprite1 row 0xFFFF_FFFF -> pixels x, x+1 = 5, 5; pixels x+2..x+15 = 15.
- hflip=1, row 0x0000_0003 at x=40 -> pixel 55 = {bank,3}, pixel 40 = 0.
- Nine enabled sprites all hitting line 50 -> sprites 0..7 drawn, sprite 8 absent, line_overflow=1 until the next frame start, then 0.
- x=630, y=475 -> pixels 630..639 drawn, nothing at 0..5; lines 475..479 drawn. Assert reset at hcount=300 -> outputs 0 immediately, INIT re-runs.
